// File: rtl/mvm_pkg.sv
// Shared constants, FSM state type and the lane multiply helper for the
// 8x8 matrix-vector multiplier.
package mvm_pkg;

    localparam int DEPTH      = 8;
    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 3 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXEC,
        DONE
    } state_t;

    // Full-width 16-bit product, zero-extended into the accumulator width.
    function automatic logic [ACC_WIDTH-1:0] macProduct(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [2*DATA_WIDTH-1:0] p;
        p = a * b;
        return {{(ACC_WIDTH - 2*DATA_WIDTH){1'b0}}, p};
    endfunction

endpackage

// File: rtl/mvm_fifo.sv
// Synchronous FIFO with registered read data; writes to a full FIFO and
// reads from an empty FIFO are ignored.
module mvm_fifo
    import mvm_pkg::*;
#(
    parameter int FIFO_DEPTH = DEPTH,
    parameter int WIDTH      = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wren,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rden,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             w_doWrite;
    logic             w_doRead;

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_doWrite = i_wren && !o_full;
    assign w_doRead  = i_rden && !o_empty;
    assign o_rdata   = r_rdata;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_rdata <= '0;
        end else begin
            if (w_doWrite) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_doRead) begin
                r_rdPtr <= nextPtr(r_rdPtr);
                r_rdata <= r_mem[r_rdPtr];
            end
            case ({w_doWrite, w_doRead})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mat_vec_mult.sv
// 8x8 matrix times 8-element vector: nine FIFOs feed a systolic row of MAC
// lanes; lane i accumulates row i dot B and holds it until cleared.
module mat_vec_mult
    import mvm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Clr,
    input  logic                  a_wren    [DEPTH-1:0],
    input  logic [DATA_WIDTH-1:0] a_fifo_in [DEPTH-1:0],
    input  logic                  b_wren,
    input  logic [DATA_WIDTH-1:0] b_fifo_in,
    output logic [ACC_WIDTH-1:0]  out       [DEPTH-1:0]
);

    localparam int CNT_W = $clog2(2 * DEPTH);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_bRden;
    logic [DEPTH-2:0]      r_aRdenSr;
    logic [DEPTH-1:0]      r_macEn;
    logic [DATA_WIDTH-1:0] r_bChain [DEPTH-1:1];
    logic [ACC_WIDTH-1:0]  r_acc    [DEPTH-1:0];

    logic [DEPTH-1:0]      w_aRden;
    logic [DEPTH-1:0]      w_aFull;
    logic [DEPTH-1:0]      w_aEmpty;
    logic [DATA_WIDTH-1:0] w_aData  [DEPTH-1:0];
    logic [DATA_WIDTH-1:0] w_bLane  [DEPTH-1:0];
    logic [DATA_WIDTH-1:0] w_bData;
    logic                  w_bFull;
    logic                  w_bEmpty;
    logic                  w_wrOpen;
    logic                  w_allFull;
    logic                  w_anyData;

    assign w_wrOpen  = (r_state == IDLE) || (r_state == LOAD);
    assign w_allFull = (&w_aFull) && w_bFull;
    assign w_anyData = !((&w_aEmpty) && w_bEmpty);
    assign w_aRden   = {r_aRdenSr, r_bRden};

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : gen_aFifo
            mvm_fifo u_aFifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_wren  (a_wren[g] && w_wrOpen),
                .i_wdata (a_fifo_in[g]),
                .i_rden  (w_aRden[g]),
                .o_rdata (w_aData[g]),
                .o_full  (w_aFull[g]),
                .o_empty (w_aEmpty[g])
            );
        end
    endgenerate

    mvm_fifo u_bFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wren  (b_wren && w_wrOpen),
        .i_wdata (b_fifo_in),
        .i_rden  (r_bRden),
        .o_rdata (w_bData),
        .o_full  (w_bFull),
        .o_empty (w_bEmpty)
    );

    // Lane i's B operand is the FIFO output delayed by i cycles.
    always_comb begin
        w_bLane[0] = w_bData;
        for (int i = 1; i < DEPTH; i++) begin
            w_bLane[i] = r_bChain[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            out[i] = r_acc[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bRden <= 1'b0;
        end else if (!Clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bRden <= 1'b0;
        end else begin
            case (r_state)
                IDLE, LOAD: begin
                    if (w_allFull) begin
                        r_state <= EXEC;
                        r_cnt   <= '0;
                        r_bRden <= 1'b1;
                    end else if (w_anyData) begin
                        r_state <= LOAD;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                // B is read for DEPTH cycles; the last lane finishes DEPTH-1 cycles later.
                EXEC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DEPTH - 1)) begin
                        r_bRden <= 1'b0;
                    end
                    if (r_cnt == CNT_W'(2 * DEPTH - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !Clr) begin
            r_aRdenSr <= '0;
            r_macEn   <= '0;
            for (int i = 1; i < DEPTH; i++) begin
                r_bChain[i] <= '0;
            end
        end else begin
            r_aRdenSr <= w_aRden[DEPTH-2:0];
            r_macEn   <= w_aRden;
            for (int i = 1; i < DEPTH; i++) begin
                r_bChain[i] <= w_bLane[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_acc[i] <= '0;
            end
        end else if (!Clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_macEn[i]) begin
                    r_acc[i] <= r_acc[i] + macProduct(w_aData[i], w_bLane[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_vec_mult.sv
// Self-checking bench for mat_vec_mult: directed and random loads compared
// against a plain-arithmetic dot-product model.
module tb_mat_vec_mult;
    import mvm_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  Clr;
    logic                  a_wren    [DEPTH-1:0];
    logic [DATA_WIDTH-1:0] a_fifo_in [DEPTH-1:0];
    logic                  b_wren;
    logic [DATA_WIDTH-1:0] b_fifo_in;
    logic [ACC_WIDTH-1:0]  out       [DEPTH-1:0];

    logic [7:0]  matA   [DEPTH][DEPTH];
    logic [7:0]  vecB   [DEPTH];
    logic [23:0] expOut [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mat_vec_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Clr       (Clr),
        .a_wren    (a_wren),
        .a_fifo_in (a_fifo_in),
        .b_wren    (b_wren),
        .b_fifo_in (b_fifo_in),
        .out       (out)
    );

    task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Result of row i dot B, reduced modulo 2^24.
    function automatic void computeModel();
        longint sum;
        for (int i = 0; i < DEPTH; i++) begin
            sum = 0;
            for (int j = 0; j < DEPTH; j++) begin
                sum += longint'(matA[i][j]) * longint'(vecB[j]);
            end
            expOut[i] = sum[23:0];
        end
    endfunction

    task automatic clearInputs();
        for (int i = 0; i < DEPTH; i++) begin
            a_wren[i]    = 1'b0;
            a_fifo_in[i] = '0;
        end
        b_wren    = 1'b0;
        b_fifo_in = '0;
    endtask

    task automatic junkInputs();
        for (int i = 0; i < DEPTH; i++) begin
            a_wren[i]    = 1'b1;
            a_fifo_in[i] = 8'($urandom);
        end
        b_wren    = 1'b1;
        b_fifo_in = 8'($urandom);
    endtask

    // Loads matA/vecB; returns just after the edge that captured the final write.
    task automatic applyStimulus(input bit randomGaps);
        int aIdx [DEPTH];
        int bIdx;
        int guard;
        bit busy;
        for (int i = 0; i < DEPTH; i++) aIdx[i] = 0;
        bIdx  = 0;
        guard = 0;
        busy  = 1'b1;
        while (busy && guard < 400) begin
            clearInputs();
            for (int i = 0; i < DEPTH; i++) begin
                if (aIdx[i] < DEPTH && (!randomGaps || $urandom_range(1, 0) == 1)) begin
                    a_wren[i]    = 1'b1;
                    a_fifo_in[i] = matA[i][aIdx[i]];
                    aIdx[i]++;
                end
            end
            if (bIdx < DEPTH && (!randomGaps || $urandom_range(1, 0) == 1)) begin
                b_wren    = 1'b1;
                b_fifo_in = vecB[bIdx];
                bIdx++;
            end
            @(negedge clk);
            guard++;
            busy = (bIdx < DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                if (aIdx[i] < DEPTH) busy = 1'b1;
            end
        end
        clearInputs();
        checkOutput("loadFinished", {23'd0, busy}, 24'd0);
    endtask

    task automatic checkLanes(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("%s lane%0d", tag, i), out[i], expOut[i]);
        end
    endtask

    task automatic checkZero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("%s lane%0d", tag, i), out[i], 24'd0);
        end
    endtask

    task automatic pulseClr(input string tag);
        Clr = 1'b0;
        @(negedge clk);
        Clr = 1'b1;
        checkZero(tag);
    endtask

    task automatic fillOnes();
        for (int i = 0; i < DEPTH; i++) begin
            vecB[i] = 8'(i + 1);
            for (int j = 0; j < DEPTH; j++) matA[i][j] = 8'd1;
        end
        computeModel();
    endtask

    task automatic fillRandom();
        for (int i = 0; i < DEPTH; i++) begin
            vecB[i] = 8'($urandom);
            for (int j = 0; j < DEPTH; j++) matA[i][j] = 8'($urandom);
        end
        computeModel();
    endtask

    initial begin
        rst_n = 1'b0;
        Clr   = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkZero("reset");
        repeat (20) @(negedge clk);
        checkZero("idleAfterReset");

        fillOnes();
        checkOutput("modelOnes", expOut[0], 24'd36);
        applyStimulus(1'b0);
        repeat (17) @(negedge clk);
        checkLanes("onesB1to8");
        repeat (10) @(negedge clk);
        checkLanes("onesHold");
        pulseClr("clrAfterOnes");

        for (int i = 0; i < DEPTH; i++) begin
            vecB[i] = 8'd2;
            for (int j = 0; j < DEPTH; j++) matA[i][j] = 8'(i + 1);
        end
        computeModel();
        applyStimulus(1'b1);
        repeat (17) @(negedge clk);
        checkLanes("rowScaled");
        pulseClr("clrAfterRows");

        for (int i = 0; i < DEPTH; i++) begin
            vecB[i] = 8'hFF;
            for (int j = 0; j < DEPTH; j++) matA[i][j] = 8'hFF;
        end
        computeModel();
        checkOutput("modelMax", expOut[7], 24'h07F008);
        applyStimulus(1'b0);
        repeat (17) @(negedge clk);
        checkLanes("allMax");
        pulseClr("clrAfterMax");

        fillOnes();
        applyStimulus(1'b0);
        repeat (4) @(negedge clk);
        junkInputs();
        repeat (3) @(negedge clk);
        clearInputs();
        repeat (10) @(negedge clk);
        checkLanes("writesInExec");
        pulseClr("clrAfterExecWrites");

        fillRandom();
        applyStimulus(1'b0);
        junkInputs();
        @(negedge clk);
        clearInputs();
        repeat (16) @(negedge clk);
        checkLanes("writeWhenFull");
        pulseClr("clrAfterFullWrite");

        for (int t = 0; t < 4; t++) begin
            fillRandom();
            applyStimulus(1'b1);
            repeat (17) @(negedge clk);
            checkLanes($sformatf("random%0d", t));
            pulseClr($sformatf("clrRandom%0d", t));
        end

        fillRandom();
        applyStimulus(1'b0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkZero("asyncResetMidExec");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkZero("idleAfterAbort");
        fillRandom();
        applyStimulus(1'b1);
        repeat (17) @(negedge clk);
        checkLanes("afterAbort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
